// File: rtl/tmds_dec_align.sv
// TMDS receive channel: finds the word boundary by requesting bitslips until control tokens
// appear, then decodes each word to video/control data. All outputs registered, 1-cycle latency.
module tmds_dec_align #(
   parameter int unsigned LOCK_TOKENS   = 64,
   parameter int unsigned SEARCH_CYCLES = 4096,
   parameter int unsigned SLIP_WAIT     = 16
) (
   input  logic       clk_pix,
   input  logic       reset,
   input  logic [9:0] tmds_i,
   output logic       bitslip_o,
   output logic       locked_o,
   output logic [3:0] slip_cnt_o,
   output logic [7:0] vd_o,
   output logic [1:0] cd_o,
   output logic       de_o
);
   typedef enum logic [1:0] {S_SEARCH, S_SLIP, S_WAIT, S_LOCKED} state_t;

   localparam logic [15:0] RUN_MAX   = 16'(LOCK_TOKENS);
   localparam logic [16:0] RUN_HIT   = 17'(LOCK_TOKENS);
   localparam logic [16:0] WD_HIT    = 17'(SEARCH_CYCLES);
   localparam logic [15:0] SRCH_LAST = 16'(SEARCH_CYCLES - 1);
   localparam logic [7:0]  WAIT_LAST = 8'(SLIP_WAIT - 1);

   state_t      state_q, state_d;
   logic [15:0] run_q, run_d, timer_q, timer_d, wd_q, wd_d;
   logic [7:0]  wait_q, wait_d;
   logic [3:0]  slip_cnt_q, slip_cnt_d;
   logic        bitslip_q, bitslip_d, locked_q, locked_d, de_q, de_d;
   logic [7:0]  vd_q, vd_d;
   logic [1:0]  cd_q, cd_d;

   logic        is_tok;
   logic [1:0]  tok_val;
   logic [7:0]  d_in, vid;
   logic [16:0] run_inc, wd_inc;

   always_comb begin
      is_tok  = 1'b1;
      tok_val = 2'b00;
      case (tmds_i)
         10'b1101010100: tok_val = 2'b00;
         10'b0010101011: tok_val = 2'b01;
         10'b0101010100: tok_val = 2'b10;
         10'b1010101011: tok_val = 2'b11;
         default:        is_tok  = 1'b0;
      endcase
   end

   // Undo the optional inversion (bit 9), then the XOR/XNOR chain selected by bit 8.
   always_comb begin
      d_in   = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0];
      vid    = '0;
      vid[0] = d_in[0];
      for (int i = 1; i < 8; i++) begin
         vid[i] = tmds_i[8] ? (d_in[i] ^ d_in[i-1]) : ~(d_in[i] ^ d_in[i-1]);
      end
   end

   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      timer_d    = timer_q;
      wd_d       = wd_q;
      wait_d     = wait_q;
      slip_cnt_d = slip_cnt_q;
      run_inc    = {1'b0, run_q} + 17'd1;
      wd_inc     = {1'b0, wd_q} + 17'd1;
      case (state_q)
         S_SEARCH: begin
            timer_d = timer_q + 16'd1;
            if (is_tok) run_d = (run_q == RUN_MAX) ? run_q : run_q + 16'd1;
            else        run_d = '0;
            // Lock takes priority over the window expiring on the same cycle.
            if (is_tok && run_inc == RUN_HIT) begin
               state_d = S_LOCKED;
               wd_d    = '0;
            end else if (timer_q == SRCH_LAST) begin
               state_d    = S_SLIP;
               slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
            end
         end
         S_SLIP: begin
            state_d = S_WAIT;
            wait_d  = '0;
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d = S_SEARCH;
               run_d   = '0;
               timer_d = '0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_LOCKED: begin
            if (is_tok) begin
               wd_d = '0;
            end else if (wd_inc == WD_HIT) begin
               state_d = S_SEARCH;
               run_d   = '0;
               timer_d = '0;
               wd_d    = '0;
            end else begin
               wd_d = wd_q + 16'd1;
            end
         end
         default: state_d = S_SEARCH;
      endcase
   end

   always_comb begin
      bitslip_d = (state_d == S_SLIP);
      locked_d  = (state_d == S_LOCKED);
      vd_d      = '0;
      cd_d      = '0;
      de_d      = 1'b0;
      if (state_d == S_LOCKED) begin
         if (is_tok) begin
            cd_d = tok_val;
         end else begin
            vd_d = vid;
            cd_d = cd_q;
            de_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         state_q    <= S_SEARCH;
         run_q      <= '0;
         timer_q    <= '0;
         wd_q       <= '0;
         wait_q     <= '0;
         slip_cnt_q <= '0;
         bitslip_q  <= 1'b0;
         locked_q   <= 1'b0;
         vd_q       <= '0;
         cd_q       <= '0;
         de_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         timer_q    <= timer_d;
         wd_q       <= wd_d;
         wait_q     <= wait_d;
         slip_cnt_q <= slip_cnt_d;
         bitslip_q  <= bitslip_d;
         locked_q   <= locked_d;
         vd_q       <= vd_d;
         cd_q       <= cd_d;
         de_q       <= de_d;
      end
   end

   assign bitslip_o  = bitslip_q;
   assign locked_o   = locked_q;
   assign slip_cnt_o = slip_cnt_q;
   assign vd_o       = vd_q;
   assign cd_o       = cd_q;
   assign de_o       = de_q;
endmodule

// File: tb/tb_tmds_dec_align.sv
// Bench for tmds_dec_align: bit-serial deserializer model with bitslip, reference model of
// the alignment/decode rules, directed vectors for the corner cases and a random phase.
module tb_tmds_dec_align;
   localparam int LT = 8, SC = 32, SW = 4;
   localparam int PERIOD = SC + 1 + SW;
   localparam int M_SEARCH = 0, M_SLIP = 1, M_WAIT = 2, M_LOCK = 3;
   localparam logic [9:0] TOKS [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};
   localparam logic [9:0] TOK0 = 10'b1101010100;
   localparam logic [9:0] VID0 = 10'b0100000000;

   logic       clk_pix = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] tmds_i = '0;
   logic       bitslip_o, locked_o, de_o;
   logic [3:0] slip_cnt_o;
   logic [7:0] vd_o;
   logic [1:0] cd_o;

   tmds_dec_align #(.LOCK_TOKENS(LT), .SEARCH_CYCLES(SC), .SLIP_WAIT(SW)) dut (
      .clk_pix(clk_pix), .reset(reset), .tmds_i(tmds_i), .bitslip_o(bitslip_o),
      .locked_o(locked_o), .slip_cnt_o(slip_cnt_o), .vd_o(vd_o), .cd_o(cd_o), .de_o(de_o)
   );

   always #5 clk_pix = ~clk_pix;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic       sbits[$];
   logic [9:0] src_q[$];
   logic [9:0] fill_word = TOK0;
   logic       prev_slip = 1'b0;

   int         m_mode = M_SEARCH;
   int         m_run = 0, m_age = 0, m_wait = 0, m_miss = 0;
   logic [3:0] m_slips = '0;
   logic       m_slip = 1'b0, m_lock = 1'b0, m_de = 1'b0;
   logic [7:0] m_vd = '0;
   logic [1:0] m_cd = '0;

   typedef struct {
      logic [9:0] w;
      logic [7:0] vd;
      logic [1:0] cd;
      logic       de;
   } vec_t;
   vec_t tbl [8];

   int slip_at[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int tok_code(input logic [9:0] w);
      for (int k = 0; k < 4; k++) if (w == TOKS[k]) return k;
      return -1;
   endfunction

   function automatic logic [7:0] vid_dec(input logic [9:0] w);
      logic [7:0] d, v;
      d = w[9] ? ~w[7:0] : w[7:0];
      v = '0;
      v[0] = d[0];
      for (int i = 1; i < 8; i++) v[i] = d[i] ^ d[i-1] ^ ~w[8];
      return v;
   endfunction

   function automatic logic [9:0] next_src();
      if (src_q.size() > 0) return src_q.pop_front();
      return fill_word;
   endfunction

   task automatic push_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) sbits.push_back(w[i]);
   endtask

   // Restart the serial stream with a new repeating word, skipping 'skip' leading bits.
   task automatic set_stream(input logic [9:0] w, input int skip);
      fill_word = w;
      src_q.delete();
      sbits.delete();
      push_word(w);
      for (int i = 0; i < skip; i++) void'(sbits.pop_front());
   endtask

   task automatic model(input logic rst, input logic [9:0] w);
      int t;
      t = tok_code(w);
      if (rst) begin
         m_mode = M_SEARCH; m_run = 0; m_age = 0; m_wait = 0; m_miss = 0;
         m_slips = '0; m_slip = 1'b0; m_lock = 1'b0; m_vd = '0; m_cd = '0; m_de = 1'b0;
         return;
      end
      case (m_mode)
         M_SEARCH: begin
            m_run = (t >= 0) ? m_run + 1 : 0;
            if (m_run >= LT) begin
               m_mode = M_LOCK;
               m_miss = 0;
            end else if (m_age == SC - 1) begin
               m_mode  = M_SLIP;
               m_slips = (m_slips == 4'd9) ? 4'd0 : m_slips + 4'd1;
            end else begin
               m_age++;
            end
         end
         M_SLIP: begin
            m_mode = M_WAIT;
            m_wait = SW;
         end
         M_WAIT: begin
            m_wait--;
            if (m_wait == 0) begin
               m_mode = M_SEARCH; m_run = 0; m_age = 0;
            end
         end
         default: begin
            if (t >= 0) m_miss = 0;
            else begin
               m_miss++;
               if (m_miss == SC) begin
                  m_mode = M_SEARCH; m_run = 0; m_age = 0; m_miss = 0;
               end
            end
         end
      endcase
      m_slip = (m_mode == M_SLIP);
      m_lock = (m_mode == M_LOCK);
      if (m_lock) begin
         if (t >= 0) begin
            m_cd = 2'(t); m_vd = '0; m_de = 1'b0;
         end else begin
            m_vd = vid_dec(w); m_de = 1'b1;
         end
      end else begin
         m_vd = '0; m_cd = '0; m_de = 1'b0;
      end
   endtask

   // One pixel clock: deliver a word, sample outputs 1 time unit after the edge,
   // compare with the model, then let the deserializer react to bitslip_o.
   task automatic step(input logic rst);
      logic [9:0] w;
      while (sbits.size() < 10) push_word(next_src());
      for (int i = 0; i < 10; i++) w[i] = sbits.pop_front();
      reset  = rst;
      tmds_i = w;
      @(posedge clk_pix);
      #1;
      cyc++;
      model(rst, w);
      chk("outputs", {15'd0, bitslip_o, locked_o, slip_cnt_o, vd_o, cd_o, de_o},
                     {15'd0, m_slip, m_lock, m_slips, m_vd, m_cd, m_de});
      chk("no_double_slip", {31'd0, prev_slip & bitslip_o}, 32'd0);
      prev_slip = bitslip_o;
      if (bitslip_o) begin
         if (sbits.size() == 0) push_word(next_src());
         void'(sbits.pop_front());
      end
   endtask

   task automatic chk_zero(input string name);
      chk(name, {15'd0, bitslip_o, locked_o, slip_cnt_o, vd_o, cd_o, de_o}, 32'd0);
   endtask

   task automatic relock_check(input string name);
      set_stream(TOK0, 0);
      repeat (LT - 1) step(1'b0);
      chk({name, "_early"}, {31'd0, locked_o}, 32'd0);
      step(1'b0);
      chk({name, "_lock"}, {31'd0, locked_o}, 32'd1);
   endtask

   initial begin
      tbl[0] = '{10'b0100000000, 8'h00, 2'b00, 1'b1};
      tbl[1] = '{10'b1000000000, 8'hFF, 2'b00, 1'b1};
      tbl[2] = '{10'b1010101011, 8'h00, 2'b11, 1'b0};
      tbl[3] = '{10'b0111111111, 8'h01, 2'b11, 1'b1};
      tbl[4] = '{10'b0010101011, 8'h00, 2'b01, 1'b0};
      tbl[5] = '{10'b1100000001, 8'h02, 2'b01, 1'b1};
      tbl[6] = '{10'b0101010100, 8'h00, 2'b10, 1'b0};
      tbl[7] = '{10'b1101010100, 8'h00, 2'b00, 1'b0};

      // Reset state, then an aligned token stream locks on the 8th word.
      step(1'b1);
      chk_zero("reset_state");
      set_stream(TOK0, 0);
      repeat (LT - 1) step(1'b0);
      chk("t1_not_yet", {31'd0, locked_o}, 32'd0);
      step(1'b0);
      chk("t1_locked", {31'd0, locked_o}, 32'd1);
      chk("t1_cd_de_slip", {25'd0, cd_o, de_o, slip_cnt_o}, 32'd0);

      // Decode vectors while locked, each response one cycle after the input.
      for (int i = 0; i < 8; i++) begin
         src_q.push_back(tbl[i].w);
         step(1'b0);
         chk($sformatf("vec%0d", i), {20'd0, locked_o, vd_o, cd_o, de_o},
             {20'd0, 1'b1, tbl[i].vd, tbl[i].cd, tbl[i].de});
      end

      // 32 non-tokens drop lock; 31 followed by a token keep it.
      repeat (SC - 1) begin src_q.push_back(VID0); step(1'b0); end
      chk("t4_still_locked", {31'd0, locked_o}, 32'd1);
      src_q.push_back(VID0);
      step(1'b0);
      chk("t4_lost", {30'd0, locked_o, de_o}, 32'd0);
      relock_check("t4_relock");
      repeat (SC - 1) begin src_q.push_back(VID0); step(1'b0); end
      src_q.push_back(TOK0);
      step(1'b0);
      chk("t4_retained", {31'd0, locked_o}, 32'd1);
      src_q.push_back(VID0);
      step(1'b0);
      chk("t4_retained_video", {30'd0, locked_o, de_o}, 32'd3);

      // Reset while locked.
      step(1'b1);
      chk_zero("t6_reset_locked");
      relock_check("t6_relock_a");

      // Misaligned by 3 bits: three slips, one period apart, then lock.
      step(1'b1);
      set_stream(TOK0, 7);
      slip_at.delete();
      for (int n = 0; n < 400 && !locked_o; n++) begin
         step(1'b0);
         if (bitslip_o) slip_at.push_back(cyc);
      end
      chk("t2_locked", {31'd0, locked_o}, 32'd1);
      chk("t2_slips", slip_at.size(), 32'd3);
      chk("t2_slip_cnt", {28'd0, slip_cnt_o}, 32'd3);
      for (int i = 1; i < slip_at.size(); i++)
         chk("t2_spacing", slip_at[i] - slip_at[i-1], PERIOD);

      // No tokens at all: periodic slips, counter wraps 9 -> 0, never locks.
      step(1'b1);
      set_stream(10'h000, 0);
      slip_at.delete();
      begin
         int ever_locked;
         ever_locked = 0;
         for (int n = 0; n < 600 && slip_at.size() < 10; n++) begin
            step(1'b0);
            if (locked_o) ever_locked = 1;
            if (bitslip_o) begin
               slip_at.push_back(cyc);
               if (slip_at.size() == 9)  chk("t5_cnt9", {28'd0, slip_cnt_o}, 32'd9);
               if (slip_at.size() == 10) chk("t5_wrap", {28'd0, slip_cnt_o}, 32'd0);
            end
         end
         chk("t5_pulses", slip_at.size(), 32'd10);
         chk("t5_never_locked", ever_locked, 32'd0);
      end
      for (int i = 1; i < slip_at.size(); i++)
         chk("t5_spacing", slip_at[i] - slip_at[i-1], PERIOD);
      chk("t5_in_slip", {31'd0, bitslip_o}, 32'd1);

      // Reset during the SLIP cycle cuts the pulse.
      step(1'b1);
      chk_zero("t6_reset_slip");
      relock_check("t6_relock_b");

      // Random phases: mostly tokens, then none, then mixed; random misalignment and resets.
      for (int ph = 0; ph < 3; ph++) begin
         int p_tok;
         p_tok = (ph == 0) ? 90 : (ph == 1) ? 0 : 60;
         set_stream(TOKS[$urandom_range(0, 3)], $urandom_range(0, 9));
         for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < p_tok) src_q.push_back(TOKS[$urandom_range(0, 3)]);
            else src_q.push_back(10'($urandom_range(0, 1023)));
            step($urandom_range(0, 299) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule

// File: doc/tmds_dec_align.md
# tmds_dec_align

Receive-side counterpart of the TMDS encoder. The block takes 10-bit parallel TMDS words from one channel's deserializer in the `clk_pix` domain and aligns the word boundary by pulsing `bitslip_o` until control tokens appear. It then decodes each word into 8-bit video data, 2-bit control data and `de`. One instance is used per HDMI/DVI channel (red, green, blue) in a receiver or loopback checker.

## Interface
Parameters:
- `LOCK_TOKENS`, 64: number of consecutive control tokens needed to declare lock (2–65535).
- `SEARCH_CYCLES`, 4096: search window length, and the consecutive token-free cycles in LOCKED that cause loss of lock (2–65535).
- `SLIP_WAIT`, 16: settle cycles after a bitslip before the search restarts (1–255).

Ports:
- `clk_pix` in 1: pixel clock, the single clock of the block.
- `reset` in 1: reset is synchronous and active-high.
- `tmds_i` in 10: parallel TMDS word from the deserializer; bit 0 is the first bit received.
- `bitslip_o` out 1: one-cycle pulse that requests a 1-bit shift from the deserializer.
- `locked_o` out 1: word alignment is valid.
- `slip_cnt_o` out 4: number of slips issued since reset, counting 0..9 and wrapping.
- `vd_o` out 8: decoded video data.
- `cd_o` out 2: decoded control data `{c1,c0}`.
- `de_o` out 1: data enable; high for video words while locked.

## Operation
- Control tokens:
  - 1101010100 decodes to 00.
  - 0010101011 decodes to 01.
  - 0101010100 decodes to 10.
  - 1010101011 decodes to 11.
  - Any other word is treated as video.
- Video decode:
  - `d = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0]`.
  - `vd[0] = d[0]`.
  - For i = 1..7: `vd[i] = tmds_i[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])`.
- The FSM has four states: SEARCH, SLIP, WAIT, LOCKED.
- SEARCH:
  - `run` is incremented (saturating at `LOCK_TOKENS`) on a token and cleared on a non-token.
  - `timer` counts from 0.
  - When the current word is a token and `run+1 == LOCK_TOKENS`, go to LOCKED.
  - Otherwise, when `timer == SEARCH_CYCLES-1`, go to SLIP.
  - If both conditions hold on the same cycle, lock wins.
- SLIP:
  - Lasts exactly 1 cycle with `bitslip_o=1`.
  - `slip_cnt_o` increments, wrapping 9→0.
  - Then go to WAIT.
- WAIT:
  - Lasts `SLIP_WAIT` cycles and ignores input.
  - Then go to SEARCH with `run` and `timer` cleared.
- LOCKED:
  - `wd` is cleared on any token and incremented on a non-token.
  - When a non-token arrives with `wd+1 == SEARCH_CYCLES`, go to SEARCH with counters cleared and no slip.
- Output gating: when the next state is LOCKED, outputs load the decode of `tmds_i`.
  - Token word: `cd_o` = token value, `de_o=0`, `vd_o=0`.
  - Video word: `vd_o` = decoded value, `de_o=1`, `cd_o` holds its previous value.
  - Otherwise `vd_o=0`, `cd_o=0`, `de_o=0`.
- Counter widths are 16 bits for `run`, `timer` and `wd`, and 8 bits for the WAIT counter.

## Timing
- Reset: on the first rising edge with `reset=1`, state becomes SEARCH and all counters clear. All outputs are 0: `bitslip_o`, `locked_o`, `slip_cnt_o`, `vd_o`, `cd_o`, `de_o`.
- Reset wins over any state, including the SLIP cycle, where the pulse is cut.
- All outputs are registered. Latency from `tmds_i` to `vd_o`/`cd_o`/`de_o` is 1 cycle.
- `locked_o` rises on the same edge that samples the `LOCK_TOKENS`-th consecutive token. `cd_o` carries that token's value from that edge.
- `locked_o` falls on the edge that samples the `SEARCH_CYCLES`-th consecutive non-token. `de_o` is 0 from that edge.
- Slip period with no tokens present is `SEARCH_CYCLES + 1 + SLIP_WAIT` cycles.
- `bitslip_o` is never high for 2 consecutive cycles.

## Test plan
Bench settings: `LOCK_TOKENS=8`, `SEARCH_CYCLES=32`, `SLIP_WAIT=4`. The bench deserializer model rotates the stream by 1 bit on each `bitslip_o`.

1. Aligned stream, 8× 1101010100 after reset → `locked_o=1` on the edge sampling the 8th word; `cd_o=00`, `de_o=0`, `slip_cnt_o=0`.
2. Stream misaligned by 3 bits, control tokens only → exactly 3 `bitslip_o` pulses, spaced 37 cycles apart; then lock; `slip_cnt_o=3`.
3. While locked: 0100000000 → `vd_o=0x00`, `de_o=1`; 1000000000 → `vd_o=0xFF`, `de_o=1`; 1010101011 → `cd_o=11`, `de_o=0`. Each response appears 1 cycle after input.
4. Locked, then 32 consecutive 0100000000 → `locked_o` drops on the 32nd word with `de_o=0`; 31 video words followed by 1 token → lock is retained.
5. Constant 0000000000 (no tokens) → `bitslip_o` pulses every 37 cycles; `slip_cnt_o` goes 9→0 on the 10th pulse; `locked_o` stays 0.
6. `reset` asserted during SLIP and during LOCKED → all outputs 0 next edge; relock takes 8 tokens.
